// File: rtl/aes_round_sequencer.sv
// Control sequencer for the AES-128 core: key expansion launch, round stepping
// with one-cycle-ahead round-key prefetch, and ciphertext output handshake.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEYGEN_MIN = 12
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       key_we,
  input  logic       gen_done,
  output logic [3:0] key_addr,
  input  logic       blk_valid,
  output logic       blk_ready,
  output logic       load_blk,
  output logic       round_en,
  output logic       final_round,
  output logic [3:0] round_num,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; valid may be held across stalled cycles and is never dropped.

  typedef enum logic [2:0] {
    S_NOKEY  = 3'd0,
    S_KEYGEN = 3'd1,
    S_READY  = 3'd2,
    S_ROUND  = 3'd3,
    S_FINAL  = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  localparam logic [3:0] LAST_R = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] NR     = 4'(NUM_ROUNDS);
  localparam logic [3:0] KMIN   = 4'(KEYGEN_MIN);

  state_t     state, state_nxt;
  logic [3:0] r, r_nxt;
  logic [3:0] w, w_nxt;
  logic [3:0] w_inc;

  // w_inc counts KEYGEN cycles including the current one.
  assign w_inc     = (w == 4'd15) ? 4'd15 : w + 4'd1;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_NOKEY;
      r     <= 4'd0;
      w     <= 4'd0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      w     <= w_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    w_nxt     = w;
    case (state)
      S_NOKEY: begin
        if (key_valid) begin
          state_nxt = S_KEYGEN;
          w_nxt     = 4'd0;
        end
      end
      S_KEYGEN: begin
        w_nxt = w_inc;
        // A gen_done level left over from a previous key is ignored until
        // the minimum expansion time has elapsed.
        if (w_inc >= KMIN && gen_done) state_nxt = S_READY;
      end
      S_READY: begin
        if (key_valid) begin
          state_nxt = S_KEYGEN;
          w_nxt     = 4'd0;
        end else if (blk_valid) begin
          state_nxt = S_ROUND;
          r_nxt     = 4'd1;
        end
      end
      S_ROUND: begin
        if (r >= LAST_R) begin
          state_nxt = S_FINAL;
          r_nxt     = NR;
        end else begin
          r_nxt = r + 4'd1;
        end
      end
      S_FINAL: state_nxt = S_OUTPUT;
      S_OUTPUT: begin
        if (out_ready) begin
          state_nxt = S_READY;
          r_nxt     = 4'd0;
        end
      end
      default: begin
        state_nxt = S_NOKEY;
        r_nxt     = 4'd0;
        w_nxt     = 4'd0;
      end
    endcase
  end

  always_comb begin
    key_ready   = 1'b0;
    blk_ready   = 1'b0;
    key_addr    = 4'd0;
    round_en    = 1'b0;
    final_round = 1'b0;
    round_num   = 4'd0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      S_NOKEY:  key_ready = 1'b1;
      S_KEYGEN: busy = 1'b1;
      S_READY: begin
        key_ready = 1'b1;
        blk_ready = !key_valid;
        key_addr  = 4'd1;
      end
      S_ROUND: begin
        busy      = 1'b1;
        round_en  = 1'b1;
        round_num = r;
        // Key generator read is registered, so address the next round's key.
        key_addr  = r + 4'd1;
      end
      S_FINAL: begin
        busy        = 1'b1;
        round_en    = 1'b1;
        final_round = 1'b1;
        round_num   = NR;
        key_addr    = NR;
      end
      S_OUTPUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: key_ready = 1'b1;
    endcase
    // Strobes stay low while reset is held even if the host drives valid.
    key_we   = key_valid & key_ready & n_rst;
    load_blk = blk_valid & blk_ready & n_rst;
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: handshake decode tables plus hand-written
// sequences; a scoreboard checks every round/output cycle after each load.
module tb_aes_round_sequencer;

  localparam int NR = 10;
  localparam logic [2:0] ST_NOKEY = 3'd0, ST_KEYGEN = 3'd1, ST_READY = 3'd2;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       key_valid = 1'b0, gen_done = 1'b0, blk_valid = 1'b0, out_ready = 1'b0;
  logic       key_ready, key_we, blk_ready, load_blk, round_en, final_round;
  logic       out_valid, busy;
  logic [3:0] key_addr, round_num;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // {round_en, final_round, round_num, key_addr, out_valid}
  logic [10:0] exp_q[$];

  typedef struct {
    logic       kv;
    logic       bv;
    logic       e_key_ready;
    logic       e_key_we;
    logic       e_blk_ready;
    logic       e_load_blk;
    logic [3:0] e_key_addr;
    logic       e_busy;
  } vec_t;

  vec_t nokey_tab[4];
  vec_t ready_tab[4];

  aes_round_sequencer #(.NUM_ROUNDS(NR), .KEYGEN_MIN(12)) dut (
    .clk(clk), .n_rst(n_rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_we(key_we),
    .gen_done(gen_done), .key_addr(key_addr),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .load_blk(load_blk),
    .round_en(round_en), .final_round(final_round), .round_num(round_num),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    key_valid = v.kv;
    blk_valid = v.bv;
    #2;
    check({tag, "_key_ready"}, 32'(key_ready), 32'(v.e_key_ready));
    check({tag, "_key_we"},    32'(key_we),    32'(v.e_key_we));
    check({tag, "_blk_ready"}, 32'(blk_ready), 32'(v.e_blk_ready));
    check({tag, "_load_blk"},  32'(load_blk),  32'(v.e_load_blk));
    check({tag, "_key_addr"},  32'(key_addr),  32'(v.e_key_addr));
    check({tag, "_busy"},      32'(busy),      32'(v.e_busy));
    key_valid = 1'b0;
    blk_valid = 1'b0;
  endtask

  // Starts at posedge+1 with gen_done already high; ends at the READY negedge.
  task automatic key_load(input string tag);
    key_valid = 1'b1;
    @(negedge clk);
    check({tag, "_key_we"}, 32'(key_we), 32'd1);
    tick();
    key_valid = 1'b0;
    @(negedge clk);
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    check({tag, "_kg_c1"}, 32'(dbg_state), 32'(ST_KEYGEN));
    for (int i = 2; i <= 12; i++) begin
      tick();
      @(negedge clk);
      check({tag, "_kg_hold"}, 32'(dbg_state), 32'(ST_KEYGEN));
    end
    tick();
    @(negedge clk);
    check({tag, "_ready_state"}, 32'(dbg_state), 32'(ST_READY));
    check({tag, "_ready_blk_ready"}, 32'(blk_ready), 32'd1);
    check({tag, "_ready_key_addr"}, 32'(key_addr), 32'd1);
    check({tag, "_ready_busy"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard: every load_blk schedules NR round cycles then the first out_valid cycle.
  always @(negedge clk) begin
    logic [10:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_round", {21'd0, round_en, final_round, round_num, key_addr, out_valid},
            {21'd0, e});
    end else begin
      check("idle_round", {26'd0, round_en, final_round, round_num}, 32'd0);
    end
    if (load_blk) begin
      for (int i = 1; i <= NR; i++)
        exp_q.push_back({1'b1, (i == NR), 4'(i), (i < NR) ? 4'(i + 1) : 4'(NR), 1'b0});
      exp_q.push_back({1'b0, 1'b0, 4'd0, 4'd0, 1'b1});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  found;
    //                kv    bv    krdy  kwe   brdy  load  addr  busy
    nokey_tab[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    nokey_tab[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    nokey_tab[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    nokey_tab[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    ready_tab[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0};
    ready_tab[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
    ready_tab[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
    ready_tab[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};

    // Reset values, with key_valid driven to confirm key_we stays low.
    key_valid = 1'b1;
    #12;
    check("rst_key_ready", 32'(key_ready), 32'd1);
    check("rst_key_we", 32'(key_we), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_NOKEY));
    check("rst_outs", {23'd0, blk_ready, load_blk, round_en, final_round, out_valid, busy,
                       |key_addr, |round_num}, 32'd0);
    key_valid = 1'b0;
    #1 n_rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      tick();
      apply(nokey_tab[i], "nokey_tab");
    end

    tick();
    gen_done = 1'b1;
    key_load("kl1");

    for (int i = 0; i < 4; i++) begin
      tick();
      apply(ready_tab[i], "ready_tab");
    end

    // Single block with 5 cycles of output backpressure.
    tick();
    out_ready = 1'b0;
    blk_valid = 1'b1;
    @(negedge clk);
    check("blk_load", 32'(load_blk), 32'd1);
    tick();
    blk_valid = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tick();
      blk_valid = 1'b1;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_blk_ready", 32'(blk_ready), 32'd0);
    end
    tick();
    blk_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_state", 32'(dbg_state), 32'(ST_READY));
    check("bp_out_valid_low", 32'(out_valid), 32'd0);

    // Back-to-back blocks with out_ready held high.
    tick();
    out_ready = 1'b1;
    blk_valid = 1'b1;
    @(negedge clk);
    check("thr_load0", 32'(load_blk), 32'd1);
    cnt = 0;
    found = 1'b0;
    for (int i = 1; i <= 30 && !found; i++) begin
      tick();
      @(negedge clk);
      if (load_blk) begin
        found = 1'b1;
        cnt = i;
      end
    end
    blk_valid = 1'b0;
    check("thr_spacing", 32'(cnt), 32'd12);
    repeat (12) tick();
    @(negedge clk);
    check("thr_ready", 32'(dbg_state), 32'(ST_READY));

    // Late gen_done: KEYGEN waits as long as needed.
    tick();
    gen_done = 1'b0;
    key_valid = 1'b1;
    @(negedge clk);
    check("late_key_we", 32'(key_we), 32'd1);
    tick();
    key_valid = 1'b0;
    repeat (19) tick();
    @(negedge clk);
    check("late_wait_state", 32'(dbg_state), 32'(ST_KEYGEN));
    check("late_wait_busy", 32'(busy), 32'd1);
    tick();
    gen_done = 1'b1;
    @(negedge clk);
    check("late_still_kg", 32'(dbg_state), 32'(ST_KEYGEN));
    tick();
    @(negedge clk);
    check("late_ready", 32'(dbg_state), 32'(ST_READY));

    // Key and block together in READY; stale gen_done must not shorten KEYGEN.
    tick();
    key_valid = 1'b1;
    blk_valid = 1'b1;
    @(negedge clk);
    check("sim_key_we", 32'(key_we), 32'd1);
    check("sim_blk_ready", 32'(blk_ready), 32'd0);
    check("sim_load_blk", 32'(load_blk), 32'd0);
    tick();
    key_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("sim_hold_state", 32'(dbg_state), 32'(ST_KEYGEN));
      check("sim_hold_load", 32'(load_blk), 32'd0);
      tick();
    end
    @(negedge clk);
    check("sim_late_load", 32'(load_blk), 32'd1);
    tick();
    blk_valid = 1'b0;
    repeat (11) tick();
    @(negedge clk);
    check("sim_done_ready", 32'(dbg_state), 32'(ST_READY));

    // Reset in the middle of a block.
    tick();
    blk_valid = 1'b1;
    @(negedge clk);
    check("mid_load", 32'(load_blk), 32'd1);
    tick();
    blk_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("mid_round5", 32'(round_num), 32'd5);
    #1;
    n_rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_key_ready", 32'(key_ready), 32'd1);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_NOKEY));
    check("mid_rst_outs", {23'd0, blk_ready, load_blk, round_en, final_round, out_valid, busy,
                           |key_addr, |round_num}, 32'd0);
    #1 n_rst = 1'b1;
    tick();
    blk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_blk_ready", 32'(blk_ready), 32'd0);
      check("post_rst_load", 32'(load_blk), 32'd0);
      check("post_rst_state", 32'(dbg_state), 32'(ST_NOKEY));
      tick();
    end
    blk_valid = 1'b0;
    key_load("kl2");
    tick();
    blk_valid = 1'b1;
    @(negedge clk);
    check("post_rst_block", 32'(load_blk), 32'd1);
    tick();
    blk_valid = 1'b0;
    repeat (11) tick();
    @(negedge clk);
    check("post_rst_done", 32'(dbg_state), 32'(ST_READY));

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control sequencer for the AES-128 encryption core. It accepts a cipher key and launches round-key expansion in `key_generator`. It then accepts 128-bit plaintext blocks one at a time and steps the round datapath through the initial AddRoundKey, nine full rounds and the final round. It prefetches each round key through the key generator's one-cycle registered read port so the key is ready on the cycle it is consumed. It sits between the host-side key/block handshakes and the `key_generator` plus round-datapath pair; it carries no 128-bit data itself.

## Interface
Parameters:
- `NUM_ROUNDS`, default 10: the number of rounds after the round-0 AddRoundKey. The last of these is the final round.
- `KEYGEN_MIN`, default 12: the minimum number of cycles spent in KEYGEN before `gen_done` is honoured.

Ports:
- `clk`  in  1: clock. All state changes on the rising edge.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `key_valid`  in  1: the host presents a new cipher key on the key generator's `input_key` bus.
- `key_ready`  out  1: the sequencer can accept a key.
- `key_we`  out  1: write strobe to `key_generator.WE_key_generation`. Equals `key_valid & key_ready`.
- `gen_done`  in  1: driven by `key_generator.generation_done`.
- `key_addr`  out  4: drives `key_generator.read_addr`.
- `blk_valid`  in  1: a plaintext block is present at the datapath input.
- `blk_ready`  out  1: the sequencer can accept a block.
- `load_blk`  out  1: the datapath latches plaintext XOR `round_key_0`. Equals `blk_valid & blk_ready`.
- `round_en`  out  1: the datapath performs one round using the current round key.
- `final_round`  out  1: the datapath skips MixColumns and uses `round_key_10`.
- `round_num`  out  4: the current round, 1..NUM_ROUNDS. Reads 0 outside rounds.
- `out_valid`  out  1: the ciphertext in the datapath state register is valid.
- `out_ready`  in  1: the host consumes the ciphertext.
- `busy`  out  1: high in KEYGEN, ROUND, FINAL and OUTPUT.

## Operation
States: NOKEY, KEYGEN, READY, ROUND, FINAL, OUTPUT. All outputs are decoded from the state, a 4-bit round counter `r`, a 4-bit wait counter `w`, and the inputs as noted.

- **NOKEY**
  - Outputs: `key_ready`=1, `blk_ready`=0.
  - `key_valid` → `key_we`=1, next state KEYGEN, `w`←0.
- **KEYGEN**
  - Outputs: `key_ready`=0.
  - `w` increments and saturates at 15.
  - `w`≥KEYGEN_MIN and `gen_done`=1 → READY.
  - The `gen_done` level is ignored before KEYGEN_MIN, because it may still be high from a previous key.
- **READY**
  - Outputs: `key_ready`=1, `blk_ready`=!`key_valid`, `key_addr`=1.
  - `key_valid` (key has priority over block) → `key_we`, next state KEYGEN, `w`←0.
  - Otherwise `blk_valid` → `load_blk`, next state ROUND, `r`←1.
- **ROUND**
  - Outputs: `round_en`=1, `round_num`=`r`, `key_addr`=`r`+1 (prefetch for the next cycle).
  - `r`<NUM_ROUNDS−1 → `r`++.
  - `r`=NUM_ROUNDS−1 → FINAL, `r`←NUM_ROUNDS.
- **FINAL**
  - Outputs: `round_en`=1, `final_round`=1, `round_num`=NUM_ROUNDS, `key_addr`=NUM_ROUNDS.
  - Next state OUTPUT.
- **OUTPUT**
  - Outputs: `out_valid`=1, held until `out_ready`.
  - `out_ready` → READY, `r`←0.
- `key_ready` and `blk_ready` are 0 in ROUND, FINAL and OUTPUT. A `key_valid` arriving then is stalled, not dropped.
- Outside the states that set it, `key_addr` reads 0.
- Counters are 4-bit and never wrap: `r`≤NUM_ROUNDS, `w` saturates at 15.

## Timing
- Reset values (and values while `n_rst`=0):
  - state NOKEY, `r`=0, `w`=0.
  - `key_ready`=1; every other output 0: `key_we`, `key_addr`, `blk_ready`, `load_blk`, `round_en`, `final_round`, `round_num`, `out_valid`, `busy`.
- Reset mid-block or mid-keygen: the operation is abandoned, no `out_valid` is produced, and a key must be reloaded.
- Key read latency: `key_generator` registers `round_key_x` from `read_addr`, so a key becomes usable one cycle after its address is driven.
  - READY drives address 1 continuously.
  - In ROUND, the address is always one round ahead of `round_num`.
- Block latency: `load_blk` at cycle T.
  - `round_en` on T+1..T+NUM_ROUNDS; `final_round` on T+NUM_ROUNDS.
  - `out_valid` from T+NUM_ROUNDS+1.
- Throughput with `out_ready` held high: the next `load_blk` comes at T+NUM_ROUNDS+2 at the earliest (12 cycles per block).
- `key_valid` and `blk_valid` on the same READY cycle: the key is accepted, the block is not (`blk_ready`=0), and the block waits until after KEYGEN.
- `gen_done` arriving early (before KEYGEN_MIN) has no effect. Arriving late, KEYGEN waits indefinitely with `busy`=1.

## Test plan
- **Reset then key load:** `key_valid` for 1 cycle → `key_we`=1 that cycle; `busy`=1 from the next cycle. Hold `gen_done`=1 throughout → READY exactly 13 cycles after `key_we` (`w` must reach 12); then `blk_ready`=1 and `key_addr`=1.
- **Single block, FIPS-197 key 000102..0f with plaintext 00112233..ff:**
  - `load_blk` at T.
  - `round_num` 1..10 on T+1..T+10, with `key_addr` 2..10,10.
  - `final_round` only at T+10; `out_valid` at T+11.
  - Ciphertext 69c4e0d8..c55a.
- **Output backpressure:** `out_ready`=0 for 5 cycles → `out_valid` stays 1 and `blk_ready` stays 0. On the `out_ready` pulse → READY next cycle.
- **Simultaneous key and block in READY:** → `key_we`=1, `blk_ready`=0, `load_blk`=0, next state KEYGEN. The block is accepted only after the new expansion completes.
- **Stale `gen_done`:** rekey while `gen_done` is still 1 → the sequencer stays in KEYGEN for 12 cycles before READY.
- **Reset mid-block:** assert `n_rst`=0 at `round_num`=5 → all outputs return to their reset values immediately and `key_ready`=1. A block offered afterwards is not accepted until a new key is loaded.
